// File: rtl/dec_rc_pkg.sv
// Shared constants and FSM state type for the decoder rate-control feeder path.
package dec_rc_pkg;

  localparam int NUM_SSM = 4;
  localparam int EVT_W   = 6;
  localparam int CNT_W   = 8;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } accState_e;

endpackage

// File: rtl/dec_ssm_acc_lane.sv
// One substream lane: saturating block accumulator. commitVal is the block total
// including this cycle's event, which the top captures when a block closes.
module dec_ssm_acc_lane
  import dec_rc_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             accEn,
  input  logic             accClr,
  input  logic             vld,
  input  logic [EVT_W-1:0] bits,
  output logic [CNT_W-1:0] commitVal,
  output logic             satHit
);

  logic [CNT_W-1:0] acc;
  logic [CNT_W:0]   addend;
  logic [CNT_W:0]   sumWide;
  logic             addEn;

  always_comb begin
    addEn     = accEn & vld;
    addend    = addEn ? {{(CNT_W + 1 - EVT_W){1'b0}}, bits} : '0;
    sumWide   = {1'b0, acc} + addend;
    commitVal = sumWide[CNT_W] ? CNT_MAX : sumWide[CNT_W-1:0];
    satHit    = addEn & sumWide[CNT_W];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (accClr) begin
      acc <= '0;
    end else if (accEn) begin
      acc <= commitVal;
    end
  end

endmodule

// File: rtl/dec_ssm_bit_accum.sv
// Per-block substream bit totals for decRateControl, with commit strobe and sticky flags.
// Optional slice statistics (slice_bits, slice_blks) are built when DEC_SSM_BIT_STATS_EN is defined.
//   state | meaning
//   IDLE  | no block open, lane events ignored
//   ACCUM | block open, lane events accumulate
module dec_ssm_bit_accum
  import dec_rc_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     slice_start,
  input  logic                     blk_start,
  input  logic                     blk_end,
  input  logic [NUM_SSM-1:0]       ssm_vld,
  input  logic [NUM_SSM*EVT_W-1:0] ssm_bits,
  output logic [CNT_W-1:0]         nxtBlkbitsSsm0,
  output logic [CNT_W-1:0]         nxtBlkbitsSsm1,
  output logic [CNT_W-1:0]         nxtBlkbitsSsm2,
  output logic [CNT_W-1:0]         nxtBlkbitsSsm3,
  output logic                     start_dec_ff1,
  output logic                     blk_sat,
  output logic                     blk_proto_err
`ifdef DEC_SSM_BIT_STATS_EN
  ,
  output logic [31:0]              slice_bits,
  output logic [15:0]              slice_blks
`endif
);

  accState_e          state, nextState;
  logic               commit, protoErr, accEn, accClr, commitD;
  logic [NUM_SSM-1:0] satHit;
  logic [CNT_W-1:0]   commitVal [NUM_SSM];
  logic [CNT_W-1:0]   totals    [NUM_SSM];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  always_comb begin
    nextState = state;
    commit    = 1'b0;
    protoErr  = 1'b0;
    if (slice_start) begin
      nextState = IDLE;
    end else begin
      case (state)
        IDLE: begin
          protoErr = blk_end;
          if (blk_start) nextState = ACCUM;
        end
        ACCUM: begin
          if (blk_end) begin
            commit = 1'b1;
            if (!blk_start) nextState = IDLE;
          end else if (blk_start) begin
            protoErr = 1'b1;
          end
        end
        default: nextState = IDLE;
      endcase
    end
  end

  // Any block boundary empties the lanes; a back-to-back block starts counting next cycle.
  assign accEn  = (state == ACCUM);
  assign accClr = slice_start | blk_start | blk_end;

  for (genvar k = 0; k < NUM_SSM; k++) begin : gLane
    dec_ssm_acc_lane uLane (
      .clk       (clk),
      .rst       (rst),
      .accEn     (accEn),
      .accClr    (accClr),
      .vld       (ssm_vld[k]),
      .bits      (ssm_bits[k*EVT_W +: EVT_W]),
      .commitVal (commitVal[k]),
      .satHit    (satHit[k])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_SSM; k++) totals[k] <= '0;
      commitD       <= 1'b0;
      start_dec_ff1 <= 1'b0;
      blk_sat       <= 1'b0;
      blk_proto_err <= 1'b0;
    end else if (slice_start) begin
      for (int k = 0; k < NUM_SSM; k++) totals[k] <= '0;
      commitD       <= 1'b0;
      start_dec_ff1 <= 1'b0;
      blk_sat       <= 1'b0;
      blk_proto_err <= 1'b0;
    end else begin
      if (commit) begin
        for (int k = 0; k < NUM_SSM; k++) totals[k] <= commitVal[k];
      end
      commitD       <= commit;
      start_dec_ff1 <= commitD;
      if (|satHit) blk_sat <= 1'b1;
      if (protoErr) blk_proto_err <= 1'b1;
    end
  end

  assign nxtBlkbitsSsm0 = totals[0];
  assign nxtBlkbitsSsm1 = totals[1];
  assign nxtBlkbitsSsm2 = totals[2];
  assign nxtBlkbitsSsm3 = totals[3];

`ifdef DEC_SSM_BIT_STATS_EN
  logic [31:0] commitSum;

  always_comb begin
    commitSum = '0;
    for (int k = 0; k < NUM_SSM; k++) commitSum = commitSum + 32'(commitVal[k]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slice_bits <= '0;
      slice_blks <= '0;
    end else if (slice_start) begin
      slice_bits <= '0;
      slice_blks <= '0;
    end else if (commit) begin
      slice_bits <= slice_bits + commitSum;
      if (slice_blks != 16'hFFFF) slice_blks <= slice_blks + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dec_ssm_bit_accum.sv
// Bench for dec_ssm_bit_accum: directed vector table, corner sequences, and randomized traffic
// compared against a block-level reference model. Stats checks build with DEC_SSM_BIT_STATS_EN.
module tb_dec_ssm_bit_accum;

  logic        clk;
  logic        rst;
  logic        slice_start, blk_start, blk_end;
  logic [3:0]  ssm_vld;
  logic [23:0] ssm_bits;
  logic [7:0]  ssm0, ssm1, ssm2, ssm3;
  logic        start_dec_ff1, blk_sat, blk_proto_err;
`ifdef DEC_SSM_BIT_STATS_EN
  logic [31:0] sliceBits;
  logic [15:0] sliceBlks;
`endif

  dec_ssm_bit_accum dut (
    .clk            (clk),
    .rst            (rst),
    .slice_start    (slice_start),
    .blk_start      (blk_start),
    .blk_end        (blk_end),
    .ssm_vld        (ssm_vld),
    .ssm_bits       (ssm_bits),
    .nxtBlkbitsSsm0 (ssm0),
    .nxtBlkbitsSsm1 (ssm1),
    .nxtBlkbitsSsm2 (ssm2),
    .nxtBlkbitsSsm3 (ssm3),
    .start_dec_ff1  (start_dec_ff1),
    .blk_sat        (blk_sat),
`ifdef DEC_SSM_BIT_STATS_EN
    .slice_bits     (sliceBits),
    .slice_blks     (sliceBlks),
`endif
    .blk_proto_err  (blk_proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nChecks = 0;
  int nFails  = 0;
  int cyc     = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    nChecks++;
    if (act != exp) begin
      nFails++;
      $display("FAIL %s cyc=%0d act=%0d exp=%0d", nm, cyc, act, exp);
    end
  endtask

  // Reference model: block-level view with plain integers.
  bit          mIn, mPend, mStr, mSat, mErr;
  int          mAcc [4];
  int          mTot [4];
  logic [31:0] mBits;
  int          mBlks;

  function automatic void mdlClear();
    mIn = 0; mPend = 0; mStr = 0; mSat = 0; mErr = 0;
    mBits = '0; mBlks = 0;
    for (int k = 0; k < 4; k++) begin
      mAcc[k] = 0;
      mTot[k] = 0;
    end
  endfunction

  function automatic void mdlStep(bit ss, bit bs, bit be, bit [3:0] v, bit [23:0] b);
    int cand [4];
    int raw, sum;
    if (ss) begin
      mdlClear();
      return;
    end
    mStr  = mPend;
    mPend = 0;
    sum   = 0;
    for (int k = 0; k < 4; k++) begin
      raw = mAcc[k] + ((mIn && v[k]) ? int'(b[k*6 +: 6]) : 0);
      if (raw > 255) begin
        mSat = 1;
        raw  = 255;
      end
      cand[k] = raw;
      sum += raw;
    end
    if (mIn && be) begin
      mTot  = cand;
      mPend = 1;
      mBits = mBits + 32'(sum);
      if (mBlks < 65535) mBlks++;
      for (int k = 0; k < 4; k++) mAcc[k] = 0;
      mIn = bs;
    end else if (mIn && bs) begin
      mErr = 1;
      for (int k = 0; k < 4; k++) mAcc[k] = 0;
    end else if (mIn) begin
      mAcc = cand;
    end else begin
      if (be) mErr = 1;
      if (bs) mIn = 1;
    end
  endfunction

  task automatic mdlCmp();
    chk("mdl_ssm0", ssm0, mTot[0]);
    chk("mdl_ssm1", ssm1, mTot[1]);
    chk("mdl_ssm2", ssm2, mTot[2]);
    chk("mdl_ssm3", ssm3, mTot[3]);
    chk("mdl_strobe", start_dec_ff1, mStr);
    chk("mdl_sat", blk_sat, mSat);
    chk("mdl_err", blk_proto_err, mErr);
`ifdef DEC_SSM_BIT_STATS_EN
    chk("mdl_slice_bits", sliceBits, mBits);
    chk("mdl_slice_blks", sliceBlks, mBlks);
`endif
  endtask

  function automatic logic [23:0] pk(int a, int b, int c, int d);
    return {d[5:0], c[5:0], b[5:0], a[5:0]};
  endfunction

  // Applies one cycle of inputs, advances past the edge, checks against the model.
  task automatic step(input bit ss, input bit bs, input bit be, input bit [3:0] v, input bit [23:0] b);
    slice_start = ss;
    blk_start   = bs;
    blk_end     = be;
    ssm_vld     = v;
    ssm_bits    = b;
    mdlStep(ss, bs, be, v, b);
    @(posedge clk);
    #1;
    cyc++;
    mdlCmp();
  endtask

  task automatic doReset();
    slice_start = 0; blk_start = 0; blk_end = 0; ssm_vld = '0; ssm_bits = '0;
    rst = 1'b1;
    #2;
    chk("rst_async_ssm0", ssm0, 0);
    chk("rst_async_strobe", start_dec_ff1, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    mdlClear();
    mdlCmp();
  endtask

  typedef struct {
    bit        ss, bs, be;
    bit [3:0]  v;
    bit [23:0] b;
    int        e0, e1, e2, e3;
    bit        eStr, eSat, eErr;
  } vec_t;

  vec_t vecs [$];

  function automatic void addVec(bit ss, bit bs, bit be, bit [3:0] v, int b0, int b1, int b2, int b3,
                                 int e0, int e1, int e2, int e3, bit eStr, bit eSat, bit eErr);
    vec_t t;
    t.ss = ss; t.bs = bs; t.be = be; t.v = v;
    t.b  = pk(b0, b1, b2, b3);
    t.e0 = e0; t.e1 = e1; t.e2 = e2; t.e3 = e3;
    t.eStr = eStr; t.eSat = eSat; t.eErr = eErr;
    vecs.push_back(t);
  endfunction

  initial begin
    bit        rss, rbs, rbe;
    bit [3:0]  rv;
    bit [23:0] rb;
    vec_t      t;

    // single block
    addVec(0,1,0,4'b0000,  0,0,0,0,   0,0,0,0, 0,0,0);
    addVec(0,0,0,4'b0001, 10,0,0,0,   0,0,0,0, 0,0,0);
    addVec(0,0,0,4'b1001, 10,0,0,5,   0,0,0,0, 0,0,0);
    addVec(0,0,1,4'b0000,  0,0,0,0,  20,0,0,5, 0,0,0);
    addVec(0,0,0,4'b1111, 33,33,33,33, 20,0,0,5, 1,0,0);
    addVec(0,0,0,4'b0000,  0,0,0,0,  20,0,0,5, 0,0,0);
    // back-to-back blocks
    addVec(0,1,0,4'b0000,  0,0,0,0,  20,0,0,5, 0,0,0);
    addVec(0,1,1,4'b0010,  0,7,0,0,   0,7,0,0, 0,0,0);
    addVec(0,0,0,4'b0010,  0,3,0,0,   0,7,0,0, 1,0,0);
    addVec(0,0,1,4'b0000,  0,0,0,0,   0,3,0,0, 0,0,0);
    addVec(0,0,0,4'b0000,  0,0,0,0,   0,3,0,0, 1,0,0);
    addVec(0,0,0,4'b0000,  0,0,0,0,   0,3,0,0, 0,0,0);
    // protocol errors
    addVec(0,0,1,4'b0000,  0,0,0,0,   0,3,0,0, 0,0,1);
    addVec(0,0,0,4'b0000,  0,0,0,0,   0,3,0,0, 0,0,1);
    addVec(0,1,0,4'b0000,  0,0,0,0,   0,3,0,0, 0,0,1);
    addVec(0,0,0,4'b0001,  9,0,0,0,   0,3,0,0, 0,0,1);
    addVec(0,1,0,4'b0001,  4,0,0,0,   0,3,0,0, 0,0,1);
    addVec(0,0,0,4'b0001,  2,0,0,0,   0,3,0,0, 0,0,1);
    addVec(0,0,1,4'b0100,  0,0,1,0,   2,0,1,0, 0,0,1);
    addVec(0,0,0,4'b0000,  0,0,0,0,   2,0,1,0, 1,0,1);
    addVec(0,0,0,4'b0000,  0,0,0,0,   2,0,1,0, 0,0,1);
    // slice_start against blk_end and against a pending strobe
    addVec(0,1,0,4'b0000,  0,0,0,0,   2,0,1,0, 0,0,1);
    addVec(0,0,0,4'b1000,  0,0,0,8,   2,0,1,0, 0,0,1);
    addVec(1,0,1,4'b1000,  0,0,0,4,   0,0,0,0, 0,0,0);
    addVec(0,0,0,4'b0000,  0,0,0,0,   0,0,0,0, 0,0,0);
    addVec(0,0,0,4'b0000,  0,0,0,0,   0,0,0,0, 0,0,0);
    addVec(0,1,0,4'b0000,  0,0,0,0,   0,0,0,0, 0,0,0);
    addVec(0,0,1,4'b0001,  6,0,0,0,   6,0,0,0, 0,0,0);
    addVec(1,0,0,4'b0000,  0,0,0,0,   0,0,0,0, 0,0,0);
    addVec(0,0,0,4'b0000,  0,0,0,0,   0,0,0,0, 0,0,0);

    rst = 1'b1;
    slice_start = 0; blk_start = 0; blk_end = 0; ssm_vld = '0; ssm_bits = '0;
    mdlClear();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ssm0", ssm0, 0);
    chk("reset_ssm3", ssm3, 0);
    chk("reset_strobe", start_dec_ff1, 0);
    chk("reset_sat", blk_sat, 0);
    chk("reset_err", blk_proto_err, 0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      t = vecs[i];
      step(t.ss, t.bs, t.be, t.v, t.b);
      chk($sformatf("vec%0d_ssm0", i), ssm0, t.e0);
      chk($sformatf("vec%0d_ssm1", i), ssm1, t.e1);
      chk($sformatf("vec%0d_ssm2", i), ssm2, t.e2);
      chk($sformatf("vec%0d_ssm3", i), ssm3, t.e3);
      chk($sformatf("vec%0d_strobe", i), start_dec_ff1, t.eStr);
      chk($sformatf("vec%0d_sat", i), blk_sat, t.eSat);
      chk($sformatf("vec%0d_err", i), blk_proto_err, t.eErr);
    end

    // saturation: 4 x 63 = 252 stays unsaturated, the fifth add clips to 255
    step(0, 1, 0, 4'b0000, '0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 4'b0100, pk(0, 0, 63, 0));
    chk("sat_not_yet", blk_sat, 0);
    step(0, 0, 1, 4'b0100, pk(0, 0, 63, 0));
    chk("sat_total", ssm2, 255);
    chk("sat_flag", blk_sat, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 4'b0000, '0);
    chk("sat_sticky", blk_sat, 1);
    step(1, 0, 0, 4'b0000, '0);
    chk("sat_cleared", blk_sat, 0);
    chk("sat_total_cleared", ssm2, 0);

    // three blocks totalling 40, 50, 60
    step(0, 1, 0, 4'b0000, '0);
    step(0, 0, 1, 4'b0001, pk(40, 0, 0, 0));
    chk("blk1_ssm0", ssm0, 40);
`ifdef DEC_SSM_BIT_STATS_EN
    chk("stats_bits_1", sliceBits, 40);
    chk("stats_blks_1", sliceBlks, 1);
`endif
    step(0, 1, 0, 4'b0000, '0);
    step(0, 0, 1, 4'b1010, pk(0, 25, 0, 25));
    step(0, 1, 0, 4'b0000, '0);
    step(0, 0, 0, 4'b0100, pk(0, 0, 30, 0));
    step(0, 0, 1, 4'b0100, pk(0, 0, 30, 0));
    chk("blk3_ssm2", ssm2, 60);
`ifdef DEC_SSM_BIT_STATS_EN
    chk("stats_bits_3", sliceBits, 150);
    chk("stats_blks_3", sliceBlks, 3);
`endif
    // reset in the middle of an open block
    step(0, 1, 0, 4'b0000, '0);
    step(0, 0, 0, 4'b1111, pk(5, 5, 5, 5));
    doReset();
    chk("rst_mid_ssm2", ssm2, 0);
`ifdef DEC_SSM_BIT_STATS_EN
    chk("rst_mid_stats_bits", sliceBits, 0);
    chk("rst_mid_stats_blks", sliceBlks, 0);
`endif
    step(0, 0, 1, 4'b0000, '0);
    step(0, 0, 0, 4'b0000, '0);
    chk("rst_mid_no_strobe", start_dec_ff1, 0);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 999) < 3) begin
        doReset();
      end else begin
        rss = ($urandom_range(0, 63) == 0);
        rbs = ($urandom_range(0, 5) == 0);
        rbe = ($urandom_range(0, 5) == 0);
        rv  = 4'($urandom);
        rb  = ($urandom_range(0, 3) == 0) ? pk(63, 62, 63, 61) : 24'($urandom);
        step(rss, rbs, rbe, rv, rb);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
    $finish;
  end

endmodule
